// File: rtl/fetch_predict_stage_pkg.sv
// Shared types and constants for the fetch/predict stage.
// Build option: FETCH_BTB_TAG_EN -- when defined, BTB entries carry a tag and
// a hit needs a tag match; when undefined, the BTB is tagless and aliasing
// PCs share entries.
package fetch_pkg;

    // 2-bit saturating branch-history counter states
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET = WEAK_NT;
    localparam logic [3:0] OPC_HLT   = 4'hF;

`ifdef FETCH_BTB_TAG_EN
    // Tag is the PC shifted right past the index bits, zero-extended to 16 bits
    typedef struct packed {
        logic        valid;
        logic [15:0] tag;
        logic [15:0] target;
    } btb_entry_t;
`else
    typedef struct packed {
        logic        valid;
        logic [15:0] target;
    } btb_entry_t;
`endif

    // Tag value for a PC given the number of index bits
    function automatic logic [15:0] btb_tag(input logic [15:0] pc, input int idx_w);
        return pc >> (idx_w + 1);
    endfunction

endpackage

// File: rtl/fetch_predict_stage_if.sv
// Fetch-stage bus: instruction memory port, IF/ID outputs and the
// resolution/training signals returned from decode.
// master: the fetch stage itself; slave: the surrounding pipeline/memory.
interface fetch_predict_stage_if;
    logic        stall;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic [15:0] pc_inst;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic [15:0] IF_ID_pc_curr;
    logic [15:0] IF_ID_pc_next;
    logic        wen_BHT;
    logic        wen_BTB;
    logic        update_PC;
    logic        actual_taken;
    logic [15:0] branch_target;

    modport master (
        input  stall, imem_rdata, IF_ID_pc_curr, IF_ID_pc_next,
               wen_BHT, wen_BTB, update_PC, actual_taken, branch_target,
        output imem_addr, pc_curr, pc_next, pc_inst,
               predicted_taken, predicted_target
    );

    modport slave (
        output stall, imem_rdata, IF_ID_pc_curr, IF_ID_pc_next,
               wen_BHT, wen_BTB, update_PC, actual_taken, branch_target,
        input  imem_addr, pc_curr, pc_next, pc_inst,
               predicted_taken, predicted_target
    );
endinterface

// File: rtl/fetch_predict_stage_branch_predictor.sv
// Direct-mapped 2-bit BHT plus BTB. Reads are combinational on the fetch PC;
// writes land on the rising edge, so a same-cycle read sees the old entry.
// Build option: FETCH_BTB_TAG_EN (tagged BTB when defined).
module branch_predictor
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rd_pc_i,
    input  logic [15:0] pc_next_i,
    input  logic [15:0] wr_pc_i,
    input  logic        wen_bht_i,
    input  logic        wen_btb_i,
    input  logic        actual_taken_i,
    input  logic [15:0] branch_target_i,
    output logic        predicted_taken_o,
    output logic [15:0] predicted_target_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    bht_state_t bht_q [ENTRIES];
    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    btb_entry_t       rd_entry_s;
    bht_state_t       rd_bht_s;
    logic             hit_s;
    bht_state_t       bht_d;
    btb_entry_t       btb_d;
    logic             unused_s;

    assign rd_idx_s = rd_pc_i[IDX_W:1];
    assign wr_idx_s = wr_pc_i[IDX_W:1];

    // PC bits that select no table state (byte offset, and the tag field when tagless)
`ifdef FETCH_BTB_TAG_EN
    assign unused_s = ^{rd_pc_i[0], wr_pc_i[0]};
`else
    assign unused_s = ^{rd_pc_i[15:IDX_W+1], rd_pc_i[0], wr_pc_i[15:IDX_W+1], wr_pc_i[0]};
`endif

    // Lookup: hit detection and prediction for the fetch PC
    always_comb begin
        rd_entry_s = btb_q[rd_idx_s];
        rd_bht_s   = bht_q[rd_idx_s];
`ifdef FETCH_BTB_TAG_EN
        hit_s = rd_entry_s.valid & (rd_entry_s.tag == btb_tag(rd_pc_i, IDX_W));
`else
        hit_s = rd_entry_s.valid;
`endif
        predicted_taken_o  = hit_s & rd_bht_s[1];
        predicted_target_o = hit_s ? rd_entry_s.target : pc_next_i;
    end

    // Saturating counter update for the entry being trained
    always_comb begin
        bht_d = bht_q[wr_idx_s];
        case (bht_q[wr_idx_s])
            STRONG_NT: bht_d = actual_taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   bht_d = actual_taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    bht_d = actual_taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  bht_d = actual_taken_i ? STRONG_T : WEAK_T;
            default:   bht_d = BHT_RESET;
        endcase
    end

    // New BTB entry built from the resolved branch in decode
    always_comb begin
        btb_d        = '0;
        btb_d.valid  = 1'b1;
`ifdef FETCH_BTB_TAG_EN
        btb_d.tag    = btb_tag(wr_pc_i, IDX_W);
`endif
        btb_d.target = branch_target_i;
    end

    // Table storage: reset clears counters to WEAK_NT and invalidates the BTB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= BHT_RESET;
                btb_q[i] <= '0;
            end
        end else begin
            if (wen_bht_i) begin
                bht_q[wr_idx_s] <= bht_d;
            end
            if (wen_btb_i) begin
                btb_q[wr_idx_s] <= btb_d;
            end
        end
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch stage: PC register, next-PC selection, HLT detect and a
// branch predictor. All outputs are combinational from the PC and tables.
// Build option: FETCH_BTB_TAG_EN (tagged BTB when defined, tagless otherwise).
module fetch_predict_stage
    import fetch_pkg::*;
#(
    parameter int          ENTRIES  = 8,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_predict_stage_if.master bus
);
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_next_s;
    logic        hlt_s;
    logic        pred_taken_s;
    logic [15:0] pred_target_s;

    assign pc_next_s            = pc_q + 16'd2;
    assign hlt_s                = (bus.imem_rdata[15:12] == OPC_HLT);
    assign bus.imem_addr        = pc_q;
    assign bus.pc_curr          = pc_q;
    assign bus.pc_next          = pc_next_s;
    assign bus.pc_inst          = bus.imem_rdata;
    assign bus.predicted_taken  = pred_taken_s;
    assign bus.predicted_target = pred_target_s;

    branch_predictor #(
        .ENTRIES (ENTRIES)
    ) u_bp (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_pc_i            (pc_q),
        .pc_next_i          (pc_next_s),
        .wr_pc_i            (bus.IF_ID_pc_curr),
        .wen_bht_i          (bus.wen_BHT),
        .wen_btb_i          (bus.wen_BTB),
        .actual_taken_i     (bus.actual_taken),
        .branch_target_i    (bus.branch_target),
        .predicted_taken_o  (pred_taken_s),
        .predicted_target_o (pred_target_s)
    );

    // Next-PC priority: redirect beats stall and HLT (HLT may be on the wrong path)
    always_comb begin
        pc_d = pc_next_s;
        if (bus.update_PC) begin
            pc_d = bus.actual_taken ? bus.branch_target : bus.IF_ID_pc_next;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (hlt_s) begin
            pc_d = pc_q;
        end else if (pred_taken_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = pc_next_s;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
